// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the word width in bytes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/halfword lane logic: load extraction with sign/zero
// extension, and sub-word merge of store data into an existing word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           wdata_rep;
  logic [WORD_BYTES-1:0] byte_en;

  always_comb begin
    byte_sel  = word[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? word[31:16] : word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Store data is replicated across all lanes; the byte enables pick the target.
  always_comb begin
    wdata_rep = wdata;
    byte_en   = '1;
    case (funct3[1:0])
      2'b00: begin
        wdata_rep = {4{wdata[7:0]}};
        byte_en   = 4'b0001 << offset;
      end
      2'b01: begin
        wdata_rep = {2{wdata[15:0]}};
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = wdata;
        byte_en   = '1;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8] : word[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-addressed memory:
// decodes and checks requests, does lane extraction and read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  localparam logic [ADDR_W-3:0] MEM_WORDS_W = (ADDR_W-2)'(MEM_WORDS);

  lsu_state_t        state_reg, state_next;
  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       merge_reg;
  logic [31:0]       resp_rdata_reg;
  logic              resp_err_reg;

  logic              fire;
  logic              f3_legal;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign fire = req_valid && req_ready;

  // Request checks are made on the live request so errors skip memory entirely.
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !req_we;
      default:          f3_legal = 1'b0;
    endcase
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = req_addr[ADDR_W-1:2] >= MEM_WORDS_W;
    req_err      = !f3_legal || misaligned || out_of_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (fire) begin
          if (req_err)                 state_next = RESP;
          else if (!req_we)            state_next = LOAD;
          else if (req_funct3 == F3_W) state_next = STORE;
          else                         state_next = RMW_RD;
        end
      end
      LOAD, STORE, RMW_WR: state_next = RESP;
      RMW_RD:              state_next = RMW_WR;
      RESP:                state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == RESP);
    mem_we     = ((state_reg == STORE) || (state_reg == RMW_WR)) && !rst;
    mem_addr   = (state_reg == IDLE) ? '0 : {addr_reg[ADDR_W-1:2], 2'b00};
    case (state_reg)
      STORE:   mem_wd = wdata_reg;
      RMW_WR:  mem_wd = merge_reg;
      default: mem_wd = '0;
    endcase
  end

  // Response registers only change on the edge that enters RESP, so they
  // hold their value between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg         <= 1'b0;
      funct3_reg     <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      merge_reg      <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      if (fire) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
      if (state_reg == RMW_RD) begin
        merge_reg <= merged_word;
      end
      if (fire && req_err) begin
        resp_err_reg   <= 1'b1;
        resp_rdata_reg <= '0;
      end else if ((state_reg == LOAD) || (state_reg == STORE) || (state_reg == RMW_WR)) begin
        resp_err_reg   <= 1'b0;
        resp_rdata_reg <= we_reg ? 32'h0 : load_data;
      end
    end
  end

  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

  lsu_lane_align u_lane_align (
    .word      (mem_rd),
    .offset    (addr_reg[1:0]),
    .funct3    (funct3_reg),
    .wdata     (wdata_reg),
    .load_data (load_data),
    .merged    (merged_word)
  );

endmodule
